// File: rtl/alu_pkg.sv
// Shared ALU constants and select-decoding helpers used by the operand
// chooser and the opcode decoder.
package alu_pkg;

  localparam int ALU_OPERAND_W  = 6;
  localparam int MAX_OPERAND_CH = 16;

  // Returns 1 when exactly one bit is set; unused upper bits must be zero.
  function automatic logic is_onehot(input logic [MAX_OPERAND_CH-1:0] sel);
    int ones;
    ones = 0;
    for (int k = 0; k < MAX_OPERAND_CH; k++) begin
      if (sel[k]) begin
        ones = ones + 1;
      end else begin
        ones = ones + 0;
      end
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/onehot_mux.sv
// Combinational AND-OR operand mux; any channel whose select bit is clear
// contributes zero, so an all-zero select yields zero.
module onehot_mux
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_OPERAND_W,
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       sel,
  output logic [WIDTH-1:0]        out_data
);

  logic [WIDTH-1:0] mux_s;

  // OR together every channel gated by its own select bit
  always_comb begin
    mux_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mux_s = mux_s | (in_data[k*WIDTH +: WIDTH] & {WIDTH{sel[k]}});
    end
  end

  assign out_data = mux_s;

endmodule

// File: rtl/alu_operand_select.sv
// Registered one-hot operand selector with a one-entry valid/ready output
// buffer; malformed selects are consumed, flagged and counted.
module alu_operand_select
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_OPERAND_W,
  parameter int NUM_CH    = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          mux_data_s;
  logic [MAX_OPERAND_CH-1:0] sel_ext_s;
  logic                      sel_ok_s;
  logic                      accept_s;

  logic [WIDTH-1:0]     out_data_r;
  logic                 out_valid_r;
  logic                 sel_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  onehot_mux #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .out_data(mux_data_s)
  );

  // Zero-extend the select so the shared one-hot check sees a fixed width
  always_comb begin
    sel_ext_s             = '0;
    sel_ext_s[NUM_CH-1:0] = sel;
  end

  assign sel_ok_s = is_onehot(sel_ext_s);
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Output buffer, error pulse and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      err_count_r <= '0;
    end else begin
      sel_err_r <= 1'b0;
      if (accept_s && sel_ok_s) begin
        out_data_r  <= mux_data_s;
        out_valid_r <= 1'b1;
      end else if (accept_s) begin
        // Bad select is swallowed: pending operand may still drain
        out_valid_r <= out_valid_r && !out_ready;
        sel_err_r   <= 1'b1;
        if (err_count_r != ERR_MAX) begin
          err_count_r <= err_count_r + ERR_ONE;
        end else begin
          err_count_r <= err_count_r;
        end
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_alu_operand_select.sv
// Directed bench for alu_operand_select: default 2x6 build, a 2-bit counter
// build for saturation and a 4x16 build for the select walk.
module tb_alu_operand_select;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance a: WIDTH=6, NUM_CH=2, ERR_CNT_W=8
  logic [11:0] a_in_data;
  logic [1:0]  a_sel;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err;
  logic [5:0]  a_out_data;
  logic [7:0]  a_err_count;

  // Instance s: WIDTH=6, NUM_CH=2, ERR_CNT_W=2
  logic [11:0] s_in_data;
  logic [1:0]  s_sel;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sel_err;
  logic [5:0]  s_out_data;
  logic [1:0]  s_err_count;

  // Instance w: WIDTH=16, NUM_CH=4, ERR_CNT_W=8
  logic [63:0] w_in_data;
  logic [3:0]  w_sel;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_sel_err;
  logic [15:0] w_out_data;
  logic [7:0]  w_err_count;

  alu_operand_select #(.WIDTH(6), .NUM_CH(2), .ERR_CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err),
    .err_count(a_err_count));

  alu_operand_select #(.WIDTH(6), .NUM_CH(2), .ERR_CNT_W(2)) u_s (
    .clk(clk), .rst(rst), .in_data(s_in_data), .sel(s_sel),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .sel_err(s_sel_err),
    .err_count(s_err_count));

  alu_operand_select #(.WIDTH(16), .NUM_CH(4), .ERR_CNT_W(8)) u_w (
    .clk(clk), .rst(rst), .in_data(w_in_data), .sel(w_sel),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .out_data(w_out_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .sel_err(w_sel_err),
    .err_count(w_err_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat[5];
    logic [15:0] exp_walk[4];
    exp_sat  = '{1, 2, 3, 3, 3};
    exp_walk = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst = 1'b1;
    a_in_data = '0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    s_in_data = '0; s_sel = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    w_in_data = '0; w_sel = '0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    tick(); tick();

    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_out_data",  32'(a_out_data),  32'd0);
    chk("reset_sel_err",   32'(a_sel_err),   32'd0);
    chk("reset_err_count", 32'(a_err_count), 32'd0);
    chk("reset_in_ready",  32'(a_in_ready),  32'd1);
    rst = 1'b0;
    tick();
    chk("post_release_idle", 32'(a_out_valid), 32'd0);

    // 1: select A then B back to back
    a_in_data = {6'h2A, 6'h15}; a_sel = 2'b01; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    chk("t1_data_a",  32'(a_out_data),  32'h15);
    chk("t1_valid_a", 32'(a_out_valid), 32'd1);
    a_sel = 2'b10;
    tick();
    chk("t1_data_b",  32'(a_out_data),  32'h2A);
    chk("t1_valid_b", 32'(a_out_valid), 32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("t1_pop_valid", 32'(a_out_valid), 32'd0);
    chk("t1_pop_hold",  32'(a_out_data),  32'h2A);

    // 2: backpressure then simultaneous pop and load
    a_sel = 2'b01; a_in_valid = 1'b1;
    tick();
    chk("t2_load", 32'(a_out_data), 32'h15);
    a_out_ready = 1'b0; a_in_data = {6'h2A, 6'h3F};
    #1;
    chk("t2_full_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk("t2_held_data",  32'(a_out_data),  32'h15);
    chk("t2_held_valid", 32'(a_out_valid), 32'd1);
    a_out_ready = 1'b1;
    #1;
    chk("t2_in_ready_up", 32'(a_in_ready), 32'd1);
    tick();
    chk("t2_swap_data",  32'(a_out_data),  32'h3F);
    chk("t2_swap_valid", 32'(a_out_valid), 32'd1);

    // 3: invalid selects 00 and 11
    a_sel = 2'b00;
    tick();
    chk("t3_err0_pulse", 32'(a_sel_err),   32'd1);
    chk("t3_err0_cnt",   32'(a_err_count), 32'd1);
    chk("t3_err0_valid", 32'(a_out_valid), 32'd0);
    chk("t3_err0_data",  32'(a_out_data),  32'h3F);
    a_sel = 2'b11;
    tick();
    chk("t3_err1_pulse", 32'(a_sel_err),   32'd1);
    chk("t3_err1_cnt",   32'(a_err_count), 32'd2);
    chk("t3_err1_data",  32'(a_out_data),  32'h3F);
    a_in_valid = 1'b0;
    tick();
    chk("t3_pulse_end", 32'(a_sel_err),   32'd0);
    chk("t3_cnt_hold",  32'(a_err_count), 32'd2);
    chk("t3_valid_low", 32'(a_out_valid), 32'd0);

    // 4: 2-bit counter saturates at 3
    s_sel = 2'b00; s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_sat_cnt",   32'(s_err_count), 32'(exp_sat[i]));
      chk("t4_sat_pulse", 32'(s_sel_err),   32'd1);
    end
    s_in_valid = 1'b0;
    tick();
    chk("t4_no_output", 32'(s_out_valid), 32'd0);

    // 6: four-channel select walk at full throughput
    w_in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_sel = 4'b0001 << i;
      tick();
      chk("t6_walk_data",  32'(w_out_data),  32'(exp_walk[i]));
      chk("t6_walk_valid", 32'(w_out_valid), 32'd1);
    end
    w_in_valid = 1'b0;
    chk("t6_no_err", 32'(w_err_count), 32'd0);

    // 5: async reset while an operand is buffered
    a_in_data = {6'h2A, 6'h15}; a_sel = 2'b10; a_in_valid = 1'b1; a_out_ready = 1'b0;
    tick();
    chk("t5_loaded", 32'(a_out_data), 32'h2A);
    a_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
    chk("t5_rst_data",  32'(a_out_data),  32'd0);
    chk("t5_rst_cnt",   32'(a_err_count), 32'd0);
    #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("t5_idle_after_release", 32'(a_out_valid), 32'd0);
    a_sel = 2'b01; a_in_valid = 1'b1;
    tick();
    chk("t5_first_data",  32'(a_out_data),  32'h15);
    chk("t5_first_valid", 32'(a_out_valid), 32'd1);
    a_in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
